or1200_fault_sched: RTL and testbench
=====================================

OR1200_FAULT_SCHED -- requirements
Module: or1200_fault_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the run cycle counter and window bounds.
REQ-002 SHALL have parameter NUM_WIN, default 4, giving the number of programmable fault windows (power of 2, at least 2).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_we_i, input, 1 bit: window configuration write strobe.
REQ-006 SHALL have port cfg_idx_i, input, log2(NUM_WIN) bits: index of the window written.
REQ-007 SHALL have port cfg_start_i / cfg_end_i, input, CNT_W bits each: inclusive window bounds.
REQ-008 SHALL have port cfg_en_i, input, 1 bit: window enable bit written with the bounds.
REQ-009 SHALL have port run_len_i, input, CNT_W bits: run length in counted cycles, sampled on arm.
REQ-010 SHALL have port arm_i, input, 1 bit: start a campaign run.
REQ-011 SHALL have port abort_i, input, 1 bit: terminate the run without a done pulse.
REQ-012 SHALL have port stall_i, input, 1 bit: hold the cycle counter (CPU stalled).
REQ-013 SHALL have port fault_sig_J, output, 1 bit: registered fault signal delivered to the core.
REQ-014 SHALL have port busy_o, output, 1 bit: high while in RUN.
REQ-015 SHALL have port done_o, output, 1 bit: one-cycle pulse at normal run completion.
REQ-016 SHALL have port cycle_o, output, CNT_W bits: current counter value.
REQ-017 SHALL have port inj_cnt_o, output, CNT_W bits: number of cycles fault_sig_J was high in the current or last run.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
REQ-019 IDLE: arm_i=1 -> RUN; counter cleared to 0, inj_cnt cleared, run_len latched.
REQ-020 IDLE with arm_i=1 and latched run_len = 0 SHALL go directly to DONE.
REQ-021 RUN: counter increments by 1 each cycle when stall_i=0 and holds when stall_i=1.
REQ-022 RUN: when the counter equals run_len-1 and stall_i=0 -> DONE; counter never wraps.
REQ-023 DONE: done_o=1 for exactly that one cycle, fault_sig_J=0, then -> IDLE unconditionally.
REQ-024 Window w SHALL be active when en[w]=1 and start[w] <= cycle_o <= end[w] (unsigned compare).
REQ-025 A window with start > end SHALL never be active.
REQ-026 Overlapping windows SHALL OR together.
REQ-027 fault_sig_J SHALL be registered: high in the cycle after cycle_o equals any active-window value while in RUN.
REQ-028 With stall_i=0, fault_sig_J SHALL be high for end-start+1 cycles per isolated window.
REQ-029 During a stall, fault_sig_J SHALL hold its current value.
REQ-030 fault_sig_J SHALL be 0 in IDLE and in DONE.
REQ-031 inj_cnt SHALL increment each cycle fault_sig_J=1, saturate at all-ones, and hold after the run.
REQ-032 cfg_we_i SHALL update window cfg_idx_i only in IDLE; writes in RUN or DONE are ignored.
REQ-033 Writes in IDLE SHALL take effect for the next arm, including a write in the same cycle as arm.
REQ-034 arm_i SHALL be ignored in RUN and DONE.
REQ-035 abort_i in RUN or DONE -> IDLE next cycle with fault_sig_J=0 and no done_o; abort_i overrides arm_i and stall_i.
REQ-036 abort_i in IDLE SHALL have no effect.

Reset
REQ-037 rst_i=1 at a clock edge SHALL force IDLE and set fault_sig_J=0, busy_o=0, done_o=0, cycle_o=0, inj_cnt_o=0, all window enables=0 and all bounds=0, regardless of state.
REQ-038 Reset mid-run SHALL drop fault_sig_J the following cycle and SHALL NOT emit done_o.

Verification
REQ-039 Window0 = 10..12 enabled, run_len=30, arm, no stall -> fault_sig_J high during cycle_o 11..13, inj_cnt_o=3, done_o pulses once after cycle_o=29, busy_o low afterwards.
REQ-040 Window0 = 5..8 and window1 = 7..10, run_len=20 -> one contiguous pulse of 6 cycles, inj_cnt_o=6.
REQ-041 Window0 = 10..12, stall_i high for 4 cycles while cycle_o=11 -> cycle_o holds at 11, fault_sig_J stays high 7 cycles total, inj_cnt_o=7.
REQ-042 abort_i at cycle_o=11 in the REQ-039 setup -> IDLE next cycle, fault_sig_J=0, no done_o, inj_cnt_o=1.
REQ-043 cfg_we_i during RUN with start=0 -> run unaffected. Then test window start=9, end=3 -> never asserts. Then run_len=0 arm -> done_o pulses after 1 cycle with fault_sig_J=0.
REQ-044 rst_i asserted at cycle_o=11 of an active window -> all outputs reset next cycle, window enables cleared, and a re-arm without reconfiguration produces no fault pulse.

Source files
------------

// File: rtl/or1200_fault_sched.sv
// Fault-injection scheduler: counts run cycles and raises a registered fault
// signal while the cycle counter falls inside any enabled programmable window.
module or1200_fault_sched #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned NUM_WIN = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_WIN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [CNT_W-1:0] cfg_start_i,
  input  logic [CNT_W-1:0] cfg_end_i,
  input  logic             cfg_en_i,
  input  logic [CNT_W-1:0] run_len_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             stall_i,
  output logic             fault_sig_J,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] inj_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] inj_q, inj_d;
  logic             fault_q, fault_d;
  logic             hit;

  logic [CNT_W-1:0] win_start_q [NUM_WIN];
  logic [CNT_W-1:0] win_end_q   [NUM_WIN];
  logic [NUM_WIN-1:0] win_en_q;

  // A window with start > end can never satisfy both bounds, so no special case.
  always_comb begin
    hit = 1'b0;
    for (int unsigned w = 0; w < NUM_WIN; w++) begin
      if (win_en_q[w] && (cycle_q >= win_start_q[w]) && (cycle_q <= win_end_q[w]))
        hit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    run_len_d = run_len_q;
    fault_d   = fault_q;
    inj_d     = inj_q;
    if (fault_q && (inj_q != '1))
      inj_d = inj_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        fault_d = 1'b0;
        if (arm_i) begin
          cycle_d   = '0;
          inj_d     = '0;
          run_len_d = run_len_i;
          state_d   = (run_len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end else if (!stall_i) begin
          if (cycle_q == (run_len_q - CNT_W'(1))) begin
            state_d = S_DONE;
            fault_d = 1'b0;
          end else begin
            cycle_d = cycle_q + CNT_W'(1);
            fault_d = hit;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      run_len_q <= '0;
      inj_q     <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      run_len_q <= run_len_d;
      inj_q     <= inj_d;
      fault_q   <= fault_d;
    end
  end

  // Window table is writable only while idle so a run sees a stable set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_en_q <= '0;
      for (int unsigned w = 0; w < NUM_WIN; w++) begin
        win_start_q[w] <= '0;
        win_end_q[w]   <= '0;
      end
    end else if (cfg_we_i && (state_q == S_IDLE)) begin
      win_start_q[cfg_idx_i] <= cfg_start_i;
      win_end_q[cfg_idx_i]   <= cfg_end_i;
      win_en_q[cfg_idx_i]    <= cfg_en_i;
    end
  end

  assign fault_sig_J = fault_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign cycle_o     = cycle_q;
  assign inj_cnt_o   = inj_q;

endmodule

// File: tb/tb_or1200_fault_sched.sv
// Directed bench for or1200_fault_sched: windowed fault pulses, stall, abort,
// ignored run-time config, empty windows, zero-length run and mid-run reset.
module tb_or1200_fault_sched;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_idx_i = '0;
  logic [15:0] cfg_start_i = '0;
  logic [15:0] cfg_end_i = '0;
  logic        cfg_en_i = 1'b0;
  logic [15:0] run_len_i = '0;
  logic        arm_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        fault_sig_J;
  logic        busy_o;
  logic        done_o;
  logic [15:0] cycle_o;
  logic [15:0] inj_cnt_o;

  int n_assert = 0;
  int n_fail = 0;

  or1200_fault_sched #(.CNT_W(16), .NUM_WIN(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_en_i(cfg_en_i),
    .run_len_i(run_len_i), .arm_i(arm_i), .abort_i(abort_i), .stall_i(stall_i),
    .fault_sig_J(fault_sig_J), .busy_o(busy_o), .done_o(done_o),
    .cycle_o(cycle_o), .inj_cnt_o(inj_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int idx, input int s, input int e, input logic en);
    cfg_idx_i   = 2'(idx);
    cfg_start_i = 16'(s);
    cfg_end_i   = 16'(e);
    cfg_en_i    = en;
    cfg_we_i    = 1'b1;
    tick;
    cfg_we_i    = 1'b0;
  endtask

  // Fault is expected while the counter shows lo+1 .. hi+1 (one-cycle register delay).
  task automatic expect_run(input string tag, input int len, input int lo, input int hi,
                            input int stall_at, input int stall_n, input int wr_at,
                            input int exp_inj);
    logic ef;
    run_len_i = 16'(len);
    arm_i = 1'b1;
    tick;
    arm_i = 1'b0;
    for (int k = 0; k < len; k++) begin
      ef = (k >= lo + 1) && (k <= hi + 1);
      if (k == stall_at) begin
        stall_i = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick;
          chk({tag, "_stall_cycle"}, 32'(cycle_o), 32'(k));
          chk({tag, "_stall_fault"}, 32'(fault_sig_J), 32'(ef));
        end
        stall_i = 1'b0;
      end
      chk({tag, "_cycle"}, 32'(cycle_o), 32'(k));
      chk({tag, "_fault"}, 32'(fault_sig_J), 32'(ef));
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      chk({tag, "_done_early"}, 32'(done_o), 32'd0);
      if (k == wr_at) begin
        cfg_idx_i   = 2'd0;
        cfg_start_i = 16'd0;
        cfg_end_i   = 16'd20;
        cfg_en_i    = 1'b1;
        cfg_we_i    = 1'b1;
      end
      tick;
      cfg_we_i = 1'b0;
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_done_fault"}, 32'(fault_sig_J), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_inj"}, 32'(inj_cnt_o), 32'(exp_inj));
    tick;
    chk({tag, "_idle_done"}, 32'(done_o), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_idle_inj"}, 32'(inj_cnt_o), 32'(exp_inj));
  endtask

  initial begin
    tick;
    tick;
    rst_i = 1'b0;
    chk("rst_fault", 32'(fault_sig_J), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cycle", 32'(cycle_o), 32'd0);
    chk("rst_inj", 32'(inj_cnt_o), 32'd0);

    // Single window 10..12 over a 30-cycle run
    cfg(0, 10, 12, 1'b1);
    expect_run("basic", 30, 10, 12, -1, 0, -1, 3);

    // Overlapping windows merge into one 6-cycle pulse
    cfg(0, 5, 8, 1'b1);
    cfg(1, 7, 10, 1'b1);
    expect_run("overlap", 20, 5, 10, -1, 0, -1, 6);
    cfg(1, 0, 0, 1'b0);

    // Stall for 4 cycles at cycle 11
    cfg(0, 10, 12, 1'b1);
    expect_run("stall", 30, 10, 12, 11, 4, -1, 7);

    // Abort at cycle 11, arm asserted alongside to show abort wins
    run_len_i = 16'd30;
    arm_i = 1'b1;
    tick;
    arm_i = 1'b0;
    for (int k = 0; k < 11; k++) tick;
    chk("abort_pre_cycle", 32'(cycle_o), 32'd11);
    chk("abort_pre_fault", 32'(fault_sig_J), 32'd1);
    abort_i = 1'b1;
    arm_i = 1'b1;
    tick;
    abort_i = 1'b0;
    arm_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_fault", 32'(fault_sig_J), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_inj", 32'(inj_cnt_o), 32'd1);
    tick;
    chk("abort_after_done", 32'(done_o), 32'd0);
    chk("abort_after_busy", 32'(busy_o), 32'd0);

    // Config write during run must be ignored (would widen window to 0..20)
    expect_run("runwr", 30, 10, 12, -1, 0, 3, 3);
    // Inverted window never fires
    cfg(0, 9, 3, 1'b1);
    expect_run("invwin", 20, 1, 0, -1, 0, -1, 0);
    // Zero-length run goes straight to DONE
    expect_run("zero", 0, 1, 0, -1, 0, -1, 0);

    // Reset mid-window, then re-arm with cleared configuration
    cfg(0, 10, 12, 1'b1);
    run_len_i = 16'd30;
    arm_i = 1'b1;
    tick;
    arm_i = 1'b0;
    for (int k = 0; k < 11; k++) tick;
    chk("mrst_pre_fault", 32'(fault_sig_J), 32'd1);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("mrst_fault", 32'(fault_sig_J), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_done", 32'(done_o), 32'd0);
    chk("mrst_cycle", 32'(cycle_o), 32'd0);
    chk("mrst_inj", 32'(inj_cnt_o), 32'd0);
    expect_run("rearm", 30, 1, 0, -1, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
